mel_fbank_acc: RTL and testbench
================================

Name: mel_fbank_acc

Overview:
- Mel filterbank accumulator. Sits directly downstream of the ping-pong bit-reversal buffer.
- Consumes one natural-order spectral magnitude bin per cycle (NUM_BINS bins per frame).
- Applies programmable triangular weights and accumulates them into NUM_FILTERS mel energies.
- At each frame end, serialises one mel energy per cycle to the next stage while the following frame accumulates.

Parameters:
- DATA_WIDTH, 8, input bin magnitude width (unsigned)
- NUM_BINS, 128, bins per frame; bin counter width BW = clog2(NUM_BINS)
- NUM_FILTERS, 16, mel filters; index width FW = clog2(NUM_FILTERS); NUM_FILTERS <= NUM_BINS required
- W_WIDTH, 8, weight width; WMAX = 2^W_WIDTH-1
- ACC_WIDTH, 24, accumulator/output width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  coefficient table write strobe
- cfg_addr  in  BW  bin index to write
- cfg_data  in  2+FW+W_WIDTH  {en_lo, en_hi, fidx, w}
- in_data  in  DATA_WIDTH  bin magnitude
- in_valid  in  1  in_data valid; no backpressure, accepted every cycle it is high
- mel_data  out  ACC_WIDTH  mel energy
- mel_idx  out  FW  filter index of mel_data
- mel_valid  out  1  mel_data/mel_idx valid
- mel_last  out  1  high with mel_valid when mel_idx = NUM_FILTERS-1

Behaviour:
- Reset (synchronous, active-high):
  - clears the bin counter, all accumulators, the shadow array, the serialiser and every table entry (all enables 0).
  - all outputs are 0 in the cycle after the reset edge.
  - reset mid-frame discards the partial frame and any serialisation in progress. The table must be reloaded after reset.
- Table: NUM_BINS register entries, written on any edge with cfg_we=1.
  - A write is visible to samples accepted at the following edge or later.
  - cfg writes during streaming are legal but unsupported for verification.
- Bin counter: increments on each accepted sample (in_valid=1 at an edge) and wraps NUM_BINS-1 -> 0. Gaps in in_valid stall nothing and lose nothing.
- Pipeline:
  - Stage 1 (accept edge E): register x = in_data, the bin index, the table entry and the is_last flag.
  - Stage 2 (edge E+1):
    - if en_lo: acc[fidx] += x*w
    - if en_hi and fidx+1 < NUM_FILTERS: acc[fidx+1] += x*(WMAX-w); otherwise the hi term is dropped
    - fidx >= NUM_FILTERS with en_lo: the lo term is dropped
- Arithmetic: unsigned. Products are DATA_WIDTH+W_WIDTH bits, zero-extended. Accumulation saturates at 2^ACC_WIDTH-1; defaults cannot overflow.
- Frame end (is_last in stage 2, edge E+1):
  - shadow[f] <= acc[f] + this cycle's contribution, for all f.
  - acc[f] <= 0.
  - Next-frame bin 0 accepted at E+1 lands on the cleared accumulators at E+2; no sample is lost or double-counted.
- Serialiser: IDLE -> DUMP on snapshot.
  - Outputs are registered. First mel_valid is at edge E+2, i.e. 2 cycles after the last bin's accept edge.
  - Emits mel_idx 0..NUM_FILTERS-1 on consecutive cycles, mel_last on the final one, then returns to IDLE.
  - A new snapshot during DUMP restarts at index 0. This is unreachable while NUM_FILTERS <= NUM_BINS.
- Outputs are held at 0 when mel_valid=0.

Optional Feature:
- Macro: MEL_LOG_COMPRESS_EN.
- Defined:
  - mel_data = log2 approximation, zero-extended to ACC_WIDTH.
  - value 0 -> 0.
  - otherwise the code is {p+1 (5 bits), m (3 bits)}, where p = MSB position and m = the 3 bits below the MSB, zero-padded if p < 3.
  - Adds 1 cycle: first mel_valid at E+3. mel_idx and mel_last are delayed to match.
- Undefined: linear accumulator values at the latency above.

Test Plan:
- Reset:
  - hold rst 2 cycles mid-stream -> mel_valid/mel_data/mel_idx/mel_last = 0 next cycle.
  - a frame with an unprogrammed table -> 16 outputs, all 0.
- Linear config and timing:
  - config bin k: {en_lo=1, en_hi=0, fidx=k/8, w=255}; 128 samples x=1 -> mel_data = 2040 for idx 0..15.
  - first mel_valid 2 cycles after bin 127's accept edge; mel_last at idx 15 only.
- Split weights: every bin {1,1,fidx=0,w=100}, x=2 -> idx0 = 25600, idx1 = 39680, idx2..15 = 0.
- Back-to-back frames: linear config, frame A x=1 immediately followed by frame B x=3 with no in_valid gap -> 2040 x16, then 6120 x16.
- Edge filter and mid-frame reset:
  - all bins {1,1,fidx=15,w=255}, x=1 -> idx15 = 32640; the hi term is dropped.
  - separately: reset after 50 bins, reload the table, send a full frame -> outputs reflect only the post-reset frame.
- MEL_LOG_COMPRESS_EN, linear config:
  - x=1 -> every mel_data = 95 (2040 -> p=10, m=7).
  - all-zero frame -> 0.
  - first mel_valid 3 cycles after the last bin.

Source files
------------

// File: rtl/mel_fbank_acc.sv
// Mel filterbank accumulator: weights natural-order spectral bins into triangular mel filters and
// serialises the per-frame energies. Define MEL_LOG_COMPRESS_EN for log2-compressed output (+1 cycle).
module mel_fbank_acc #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_BINS    = 128,
    parameter int NUM_FILTERS = 16,
    parameter int W_WIDTH     = 8,
    parameter int ACC_WIDTH   = 24,
    localparam int BW = $clog2(NUM_BINS),
    localparam int FW = $clog2(NUM_FILTERS),
    localparam int CW = 2 + FW + W_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [BW-1:0]         cfg_addr,
    input  logic [CW-1:0]         cfg_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [ACC_WIDTH-1:0]  mel_data,
    output logic [FW-1:0]         mel_idx,
    output logic                  mel_valid,
    output logic                  mel_last
);

    localparam int PW = DATA_WIDTH + W_WIDTH;
    localparam logic [W_WIDTH-1:0]   WMAX    = {W_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    typedef enum logic [0:0] {IDLE = 1'b0, DUMP = 1'b1} state_t;

    logic [CW-1:0]         tbl_r [NUM_BINS];
    logic [BW-1:0]         bin_cnt_r;
    logic                  s1_valid_r;
    logic                  s1_last_r;
    logic [DATA_WIDTH-1:0] s1_x_r;
    logic                  s1_en_lo_r;
    logic                  s1_en_hi_r;
    logic [FW-1:0]         s1_fidx_r;
    logic [W_WIDTH-1:0]    s1_w_r;
    logic [ACC_WIDTH-1:0]  acc_r    [NUM_FILTERS];
    logic [ACC_WIDTH-1:0]  shadow_r [NUM_FILTERS];
    logic [ACC_WIDTH-1:0]  sum_s    [NUM_FILTERS];
    logic [PW-1:0]         prod_lo_s;
    logic [PW-1:0]         prod_hi_s;
    logic                  snap_s;
    state_t                state_r;
    state_t                state_s;
    logic [FW-1:0]         cnt_r;
    logic [ACC_WIDTH-1:0]  data_r;
    logic [FW-1:0]         idx_r;
    logic                  valid_r;
    logic                  last_r;

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [PW-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + (ACC_WIDTH + 1)'(b);
        if (s[ACC_WIDTH]) begin
            return ACC_MAX;
        end else begin
            return s[ACC_WIDTH-1:0];
        end
    endfunction

    // Coefficient table: one {en_lo, en_hi, fidx, w} entry per bin
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                tbl_r[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_r[cfg_addr] <= cfg_data;
        end
    end

    // Stage 1: capture sample, its table entry and frame-end flag; advance bin counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt_r  <= '0;
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_x_r     <= '0;
            s1_en_lo_r <= 1'b0;
            s1_en_hi_r <= 1'b0;
            s1_fidx_r  <= '0;
            s1_w_r     <= '0;
        end else begin
            s1_valid_r <= in_valid;
            s1_x_r     <= in_data;
            s1_last_r  <= (bin_cnt_r == BW'(NUM_BINS - 1));
            {s1_en_lo_r, s1_en_hi_r, s1_fidx_r, s1_w_r} <= tbl_r[bin_cnt_r];
            if (in_valid) begin
                bin_cnt_r <= (bin_cnt_r == BW'(NUM_BINS - 1)) ? '0 : bin_cnt_r + BW'(1);
            end
        end
    end

    // Stage 2 datapath: each filter receives at most one term (lo to fidx, hi to fidx+1)
    always_comb begin
        prod_lo_s = PW'(s1_x_r) * PW'(s1_w_r);
        prod_hi_s = PW'(s1_x_r) * PW'(WMAX - s1_w_r);
        snap_s    = s1_valid_r && s1_last_r;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            sum_s[f] = acc_r[f];
            if (s1_valid_r && s1_en_lo_r && (int'(s1_fidx_r) == f)) begin
                sum_s[f] = sat_add(acc_r[f], prod_lo_s);
            end else if (s1_valid_r && s1_en_hi_r && (int'(s1_fidx_r) + 1 == f)) begin
                sum_s[f] = sat_add(acc_r[f], prod_hi_s);
            end else begin
                sum_s[f] = acc_r[f];
            end
        end
    end

    // Accumulators; at frame end the final sums move to the shadow array and accumulation restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                acc_r[f]    <= '0;
                shadow_r[f] <= '0;
            end
        end else if (snap_s) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                shadow_r[f] <= sum_s[f];
                acc_r[f]    <= '0;
            end
        end else begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                acc_r[f] <= sum_s[f];
            end
        end
    end

    // Serialiser state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Serialiser next state; a snapshot always (re)starts a dump
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (snap_s) begin
                    state_s = DUMP;
                end else begin
                    state_s = IDLE;
                end
            end
            DUMP: begin
                if (snap_s) begin
                    state_s = DUMP;
                end else if (cnt_r == FW'(NUM_FILTERS - 1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = DUMP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Dump index and registered linear outputs, forced to zero when not dumping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            data_r  <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            if (snap_s) begin
                cnt_r <= '0;
            end else if (state_r == DUMP) begin
                cnt_r <= cnt_r + FW'(1);
            end else begin
                cnt_r <= '0;
            end
            valid_r <= (state_r == DUMP);
            data_r  <= (state_r == DUMP) ? shadow_r[cnt_r] : '0;
            idx_r   <= (state_r == DUMP) ? cnt_r : '0;
            last_r  <= (state_r == DUMP) && (cnt_r == FW'(NUM_FILTERS - 1));
        end
    end

`ifdef MEL_LOG_COMPRESS_EN
    logic [ACC_WIDTH-1:0] lg_data_r;
    logic [FW-1:0]        lg_idx_r;
    logic                 lg_valid_r;
    logic                 lg_last_r;

    // Code is {msb_pos+1, three bits below the msb}; left-normalising zero-pads short values
    function automatic logic [ACC_WIDTH-1:0] log_code(input logic [ACC_WIDTH-1:0] v);
        logic [4:0]           pos;
        logic [ACC_WIDTH-1:0] norm;
        logic [2:0]           man;
        pos = 5'd0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (v[i]) begin
                pos = 5'(i);
            end
        end
        norm = v << (5'(ACC_WIDTH - 1) - pos);
        man  = 3'(norm >> (ACC_WIDTH - 4));
        if (v == '0) begin
            return '0;
        end else begin
            return ACC_WIDTH'({pos + 5'd1, man});
        end
    endfunction

    // Compression stage; index and flags travel alongside to stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            lg_data_r  <= '0;
            lg_idx_r   <= '0;
            lg_valid_r <= 1'b0;
            lg_last_r  <= 1'b0;
        end else begin
            lg_data_r  <= log_code(data_r);
            lg_idx_r   <= idx_r;
            lg_valid_r <= valid_r;
            lg_last_r  <= last_r;
        end
    end

    assign mel_data  = lg_data_r;
    assign mel_idx   = lg_idx_r;
    assign mel_valid = lg_valid_r;
    assign mel_last  = lg_last_r;
`else
    assign mel_data  = data_r;
    assign mel_idx   = idx_r;
    assign mel_valid = valid_r;
    assign mel_last  = last_r;
`endif

endmodule

// File: tb/tb_mel_fbank_acc.sv
// Directed scoreboard bench for mel_fbank_acc: expected mel outputs are queued as frames are driven
// and checked by a negedge monitor; also checks output latency and reset behaviour.
module tb_mel_fbank_acc;

    localparam int DW = 8;
    localparam int NB = 128;
    localparam int NF = 16;
    localparam int WW = 8;
    localparam int AW = 24;
    localparam int BW = 7;
    localparam int FW = 4;
`ifdef MEL_LOG_COMPRESS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [BW-1:0]     cfg_addr;
    logic [2+FW+WW-1:0] cfg_data;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic [AW-1:0]     mel_data;
    logic [FW-1:0]     mel_idx;
    logic              mel_valid;
    logic              mel_last;

    mel_fbank_acc dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .in_data  (in_data),
        .in_valid (in_valid),
        .mel_data (mel_data),
        .mel_idx  (mel_idx),
        .mel_valid(mel_valid),
        .mel_last (mel_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] data;
        logic [FW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            acc_q[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            mon_en = 1'b0;
    logic [AW-1:0] ev [NF];
    exp_t          e;
    int            lat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW-1:0] exp_of(input logic [AW-1:0] v);
`ifdef MEL_LOG_COMPRESS_EN
        int p;
        logic [2:0] m;
        if (v == '0) return '0;
        p = 0;
        for (int i = 0; i < AW; i++) if (v[i]) p = i;
        m = 3'b000;
        for (int j = 1; j <= 3; j++) if (p - j >= 0) m[3-j] = v[p-j];
        return AW'((p + 1) * 8 + int'(m));
`else
        return v;
`endif
    endfunction

    // Output monitor: pops the scoreboard on every valid output, checks idle outputs are zero
    always @(negedge clk) begin
        if (mon_en) begin
            if (mel_valid === 1'b1) begin
                vectors++;
                assert (sb.size() > 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_output observed idx=%0d data=%0d expected none", mel_idx, mel_data);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    vectors++;
                    assert ({mel_data, mel_idx, mel_last} === {e.data, e.idx, e.last}) else begin
                        miscompares++;
                        $error("FAIL mel_out observed data=%0d idx=%0d last=%0b expected data=%0d idx=%0d last=%0b",
                               mel_data, mel_idx, mel_last, e.data, e.idx, e.last);
                    end
                    if (e.idx == '0) begin
                        vectors++;
                        lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
                        assert (lat === LAT) else begin
                            miscompares++;
                            $error("FAIL latency observed=%0d expected=%0d", lat, LAT);
                        end
                    end
                end
            end else begin
                vectors++;
                assert ({mel_valid, mel_data, mel_idx, mel_last} === '0) else begin
                    miscompares++;
                    $error("FAIL idle_outputs observed valid=%b data=%0h idx=%0h last=%b expected all 0",
                           mel_valid, mel_data, mel_idx, mel_last);
                end
            end
        end
    end

    task automatic push_frame();
        for (int f = 0; f < NF; f++) begin
            sb.push_back('{data: exp_of(ev[f]), idx: FW'(f), last: (f == NF - 1)});
        end
    endtask

    task automatic set_ev(input logic [AW-1:0] v);
        for (int f = 0; f < NF; f++) ev[f] = v;
    endtask

    // mode 0: linear (fidx=k/8, w=255), 1: split (fidx=0, w=100), 2: edge filter (fidx=15, w=255)
    task automatic load_table(input int mode);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = BW'(k);
            case (mode)
                0:       cfg_data = {1'b1, 1'b0, FW'(k / 8), 8'd255};
                1:       cfg_data = {1'b1, 1'b1, 4'd0, 8'd100};
                default: cfg_data = {1'b1, 1'b1, 4'd15, 8'd255};
            endcase
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send_frame(input int x, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(x);
            if (i == NB - 1) acc_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = '0;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        assert ({mel_valid, mel_data, mel_idx, mel_last} === '0) else begin
            miscompares++;
            $error("FAIL %s observed valid=%b data=%0d idx=%0d last=%b expected all 0",
                   tag, mel_valid, mel_data, mel_idx, mel_last);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; in_data = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_state");
        rst    = 1'b0;
        mon_en = 1'b1;

        // unprogrammed table: sixteen zero outputs
        set_ev('0); push_frame();
        send_frame(1, NB); idle(30);

        // linear config, x=1
        load_table(0);
        set_ev(24'd2040); push_frame();
        send_frame(1, NB); idle(30);

        // all-zero frame on linear config
        set_ev('0); push_frame();
        send_frame(0, NB); idle(30);

        // split weights, x=2
        load_table(1);
        set_ev('0); ev[0] = 24'd25600; ev[1] = 24'd39680; push_frame();
        send_frame(2, NB); idle(30);

        // back-to-back frames with no gap
        load_table(0);
        set_ev(24'd2040); push_frame();
        send_frame(1, NB);
        set_ev(24'd6120); push_frame();
        send_frame(3, NB); idle(40);

        // edge filter: hi term beyond the last filter is dropped
        load_table(2);
        set_ev('0); ev[NF-1] = 24'd32640; push_frame();
        send_frame(1, NB); idle(30);

        // mid-frame reset held 2 cycles while samples keep arriving
        load_table(0);
        send_frame(5, 50);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        check_zero_outputs("mid_reset");
        load_table(0);
        set_ev(24'd2040); push_frame();
        send_frame(1, NB); idle(10);

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
        vectors++;
        assert (sb.size() == 0 && acc_q.size() == 0) else begin
            miscompares++;
            $error("FAIL drain observed pending=%0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
